// File: rtl/frame_gen_param.sv
// Parameterised Ethernet-style frame generator: IDLE -> START -> DATA -> EOF,
// with fixed, incrementing or PRBS payload and a programmable inter-frame gap.
module frame_gen_param #(
  parameter int          DATA_WIDTH    = 64,
  parameter int          CTRL_WIDTH    = DATA_WIDTH / 8,
  parameter logic [7:0]  IDLE_CODE     = 8'h07,
  parameter logic [7:0]  START_CODE    = 8'hFB,
  parameter logic [7:0]  EOF_CODE      = 8'hFD,
  parameter logic [7:0]  PREAMBLE_BYTE = 8'h55,
  parameter logic [7:0]  FILL_BYTE     = 8'hAA,
  parameter int          MAX_CYCLES    = 188,
  parameter logic [31:0] LFSR_SEED     = 32'hFFFF_FFFF
) (
  input  logic                              clk,
  input  logic                              i_rst_n,
  input  logic                              i_enable,
  input  logic [1:0]                        i_mode,
  input  logic [$clog2(MAX_CYCLES+1)-1:0]   i_payload_cycles,
  input  logic [7:0]                        i_ipg_cycles,
  output logic [DATA_WIDTH-1:0]             o_tx_data,
  output logic [CTRL_WIDTH-1:0]             o_tx_ctrl,
  output logic                              o_frame_done,
  output logic [15:0]                       o_frame_count,
  output logic                              o_busy
);

  localparam int LEN_W = $clog2(MAX_CYCLES + 1);

  localparam logic [DATA_WIDTH-1:0] IDLE_WORD  = {CTRL_WIDTH{IDLE_CODE}};
  localparam logic [DATA_WIDTH-1:0] START_WORD = {{(CTRL_WIDTH-1){PREAMBLE_BYTE}}, START_CODE};
  localparam logic [DATA_WIDTH-1:0] EOF_WORD   = {{(CTRL_WIDTH-1){IDLE_CODE}}, EOF_CODE};
  localparam logic [DATA_WIDTH-1:0] FILL_WORD  = {CTRL_WIDTH{FILL_BYTE}};

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_EOF} state_t;

  state_t            state;
  logic [1:0]        mode_q;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  data_cnt;
  logic [LEN_W-1:0]  len_clamped;
  logic [7:0]        ipg_q;
  logic              ipg_valid;
  logic [7:0]        idle_cnt;
  logic [7:0]        gap_raw;
  logic [7:0]        gap_min;
  logic              idle_done;
  logic [7:0]        byte_off;
  logic [31:0]       lfsr;
  logic [DATA_WIDTH-1:0] inc_word;
  logic [DATA_WIDTH-1:0] data_word;

  // x^32 + x^22 + x^2 + x + 1, advanced 32 single-bit steps.
  function automatic logic [31:0] lfsr_adv32(input logic [31:0] s);
    logic [31:0] r;
    r = s;
    for (int i = 0; i < 32; i++)
      r = {r[30:0], r[31] ^ r[21] ^ r[1] ^ r[0]};
    return r;
  endfunction

  // Until the first START has latched a gap, the live port value sets the gap.
  assign gap_raw   = ipg_valid ? ipg_q : i_ipg_cycles;
  assign gap_min   = (gap_raw == 8'd0) ? 8'd1 : gap_raw;
  assign idle_done = ({1'b0, idle_cnt} + 9'd1) >= {1'b0, gap_min};

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    len_clamped = i_payload_cycles;
    if (i_payload_cycles == '0)
      len_clamped = LEN_W'(1);
    else if (i_payload_cycles > LEN_W'(MAX_CYCLES))
      len_clamped = LEN_W'(MAX_CYCLES);
  end

  always_comb begin
    inc_word = '0;
    for (int k = 0; k < CTRL_WIDTH; k++)
      inc_word[8*k +: 8] = byte_off + 8'(k);
  end

  always_comb begin
    data_word = FILL_WORD;
    case (mode_q)
      2'b01:   data_word = inc_word;
      2'b10:   data_word = {(DATA_WIDTH/32){lfsr}};
      default: data_word = FILL_WORD;
    endcase
  end

  // Outputs are registered from the current state, so they trail it by one cycle.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state         <= S_IDLE;
      o_tx_data     <= IDLE_WORD;
      o_tx_ctrl     <= '1;
      o_frame_done  <= 1'b0;
      o_frame_count <= '0;
      o_busy        <= 1'b0;
      lfsr          <= LFSR_SEED;
      mode_q        <= '0;
      len_q         <= '0;
      data_cnt      <= '0;
      ipg_q         <= '0;
      ipg_valid     <= 1'b0;
      idle_cnt      <= '0;
      byte_off      <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      o_frame_done <= 1'b0;
      case (state)
        S_IDLE: begin
          o_tx_data <= IDLE_WORD;
          o_tx_ctrl <= '1;
          o_busy    <= 1'b0;
          if (idle_done && i_enable) begin
            state    <= S_START;
            idle_cnt <= '0;
          end else if (idle_cnt != 8'hFF) begin
            idle_cnt <= idle_cnt + 8'd1;
          end
        end
        S_START: begin
          o_tx_data <= START_WORD;
          o_tx_ctrl <= CTRL_WIDTH'(1);
          o_busy    <= 1'b1;
          mode_q    <= i_mode;
          len_q     <= len_clamped;
          ipg_q     <= i_ipg_cycles;
          ipg_valid <= 1'b1;
          lfsr      <= LFSR_SEED;
          byte_off  <= '0;
          data_cnt  <= '0;
          state     <= S_DATA;
        end
        S_DATA: begin
          o_tx_data <= data_word;
          o_tx_ctrl <= '0;
          o_busy    <= 1'b1;
          lfsr      <= lfsr_adv32(lfsr);
          byte_off  <= byte_off + 8'(CTRL_WIDTH);
          if (data_cnt == len_q - LEN_W'(1)) begin
            state    <= S_EOF;
            data_cnt <= '0;
          end else begin
            data_cnt <= data_cnt + LEN_W'(1);
          end
        end
        S_EOF: begin
          o_tx_data     <= EOF_WORD;
          o_tx_ctrl     <= '1;
          o_busy        <= 1'b1;
          o_frame_done  <= 1'b1;
          o_frame_count <= o_frame_count + 16'd1;
          idle_cnt      <= '0;
          state         <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/frame_gen_param.md
FRAME_GEN_PARAM -- requirements
Module: frame_gen_param

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64, meaning transmit word width in bits; legal values are multiples of 32 from 32 to 256.
REQ-002 SHALL have parameter CTRL_WIDTH, default DATA_WIDTH/8, meaning one control bit per byte lane.
REQ-003 SHALL have parameters IDLE_CODE 8'h07, START_CODE 8'hFB, EOF_CODE 8'hFD and PREAMBLE_BYTE 8'h55, which are the control and preamble characters.
REQ-004 SHALL have parameter FILL_BYTE, default 8'hAA, meaning the fixed-mode payload byte.
REQ-005 SHALL have parameter MAX_CYCLES, default 188, meaning the maximum number of data cycles per frame; the length port width is $clog2(MAX_CYCLES+1).
REQ-006 SHALL have parameter LFSR_SEED, default 32'hFFFF_FFFF, meaning the PRBS seed; a value of 0 is illegal.
REQ-007 clk  in  1  single clock, rising edge.
REQ-008 i_rst_n  in  1  asynchronous, active-low reset.
REQ-009 i_enable  in  1  permits new frames to start.
REQ-010 i_mode  in  2  payload mode: 00 fixed, 01 incrementing byte, 10 PRBS, 11 reserved (treated as 00).
REQ-011 i_payload_cycles  in  $clog2(MAX_CYCLES+1)  requested data cycles per frame.
REQ-012 i_ipg_cycles  in  8  requested idle cycles between frames.
REQ-013 o_tx_data  out  DATA_WIDTH  transmit word; lane k is bits [8k+7:8k], and lane 0 goes first.
REQ-014 o_tx_ctrl  out  CTRL_WIDTH  per-lane control flag; bit k covers lane k.
REQ-015 o_frame_done  out  1  one-cycle pulse that coincides with the EOF word.
REQ-016 o_frame_count  out  16  count of completed frames; wraps modulo 2^16.
REQ-017 o_busy  out  1  high while in the START, DATA or EOF states.

Function
REQ-018 The block SHALL be an FSM with states IDLE, START, DATA and EOF; all outputs are registered, and the output word reflects the state of the previous clock edge (1-cycle latency).
REQ-019 In IDLE, the output SHALL be all lanes IDLE_CODE with ctrl all 1s.
REQ-020 In IDLE, the block SHALL stay at least max(i_ipg_cycles,1) cycles, counting from EOF exit; it moves to START only if i_enable=1 at the end of that interval, and otherwise waits in IDLE.
REQ-021 In START, the output SHALL be lane0=START_CODE with ctrl bit0=1, and all other lanes PREAMBLE_BYTE with ctrl 0.
REQ-022 In START, the block SHALL latch i_mode, i_payload_cycles and i_ipg_cycles; port changes during a frame have no effect until the next START.
REQ-023 The latched length SHALL be clamped: 0 becomes 1, and values above MAX_CYCLES become MAX_CYCLES.
REQ-024 In DATA, ctrl SHALL be all 0 and the payload follows the latched mode.
REQ-025 After exactly the latched length of DATA cycles, the FSM SHALL go to EOF.
REQ-026 Fixed mode SHALL put FILL_BYTE in every lane.
REQ-027 Incrementing mode SHALL make the byte at frame payload offset n equal to n mod 256; offset 0 is lane0 of the first DATA cycle, and the value wraps 255->0.
REQ-028 PRBS mode SHALL use a 32-bit Fibonacci LFSR with polynomial x^32+x^22+x^2+x+1, reloaded with LFSR_SEED at each START.
REQ-029 In PRBS mode, the first DATA word SHALL be the seed replicated DATA_WIDTH/32 times; the LFSR advances 32 bit-steps per DATA cycle.
REQ-030 In EOF, the output SHALL be lane0=EOF_CODE and all other lanes IDLE_CODE, with ctrl all 1s; o_frame_done=1 and o_frame_count increments in this same cycle.
REQ-031 From EOF, the FSM SHALL always go to IDLE.
REQ-032 If i_enable deasserts mid-frame, the current frame SHALL complete normally through EOF.
REQ-033 In the reserved mode (11), the block SHALL generate a fixed-mode payload.

Reset
REQ-034 Assertion of i_rst_n=0 SHALL immediately force: state IDLE, o_tx_data all IDLE_CODE, o_tx_ctrl all 1s, o_frame_done 0, o_frame_count 0, o_busy 0, LFSR=LFSR_SEED, and all counters 0.
REQ-035 A reset applied mid-frame SHALL abort the frame without emitting EOF, and the count SHALL NOT increment.
REQ-036 After reset release, the first START SHALL occur no earlier than max(i_ipg_cycles,1) IDLE cycles.

Verification
REQ-037 DATA_WIDTH=64, fixed mode, length 3, ipg 2, enable=1 -> repeating sequence: 2 IDLE words, START 0x555555555555_55FB (ctrl 0x01), 3 words 0xAAAA_AAAA_AAAA_AAAA (ctrl 0x00), EOF 0x0707070707_0707FD (ctrl 0xFF) with done pulse; count increments by 1 per frame.
REQ-038 Incrementing mode, length 2 -> DATA words 0x0706050403020100 and 0x0F0E0D0C0B0A0908.
REQ-039 Length 0 -> exactly 1 DATA cycle; length MAX_CYCLES+5 (where representable) -> exactly MAX_CYCLES DATA cycles.
REQ-040 PRBS mode, seed 0xFFFFFFFF, DATA_WIDTH=64 -> first DATA word 0xFFFFFFFF_FFFFFFFF; later words match the reference model, and the model restarts identically each frame.
REQ-041 Reset pulsed during the 2nd DATA cycle -> the next word is the IDLE pattern, count stays 0, and no done pulse occurs.
REQ-042 i_enable dropped during DATA -> the frame completes with EOF, then IDLE is held indefinitely; re-raising i_enable -> START after the IPG.
